// File: rtl/prbs_uart_pkg.sv
// Shared constants, transmitter state encoding and digit formatting for the PRBS UART streamer.
package prbs_uart_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_NL = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Upper-case hex digit for a 4-bit value.
  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_0 + {4'h0, nib};
    return ASCII_A + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/prbs_uart_streamer_uart_tx_byte.sv
// 8N1 byte serialiser. A new byte may be accepted on the final cycle of a stop
// bit, so consecutive characters leave no idle gap on the line.
module uart_tx_byte
  import prbs_uart_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned    CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);

  tx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n;
  logic          bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign ready   = (state == IDLE) || ((state == STOP) && bit_end);

  // State, baud counter, shift register and registered line output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
    end
  end

  // Bit sequencing: start, eight data bits LSB first, stop; each DIV cycles.
  always_comb begin
    state_n   = state;
    cnt_n     = bit_end ? '0 : cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = tx;
    case (state)
      IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
        if (valid) begin
          state_n = START;
          tx_n    = 1'b0;
          shreg_n = data;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
          tx_n      = shreg[0];
          shreg_n   = {1'b0, shreg[7:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            tx_n      = shreg[0];
            shreg_n   = {1'b0, shreg[7:1]};
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (valid) begin
            state_n = START;
            tx_n    = 1'b0;
            shreg_n = data;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/prbs_uart_streamer.sv
// Streams LFSR words as ASCII lines (binary or hex digits plus newline) over a UART.
module prbs_uart_streamer
  import prbs_uart_pkg::*;
#(
  parameter int unsigned       CLK_HZ = 48000000,
  parameter int unsigned       BAUD   = 9600,
  parameter int unsigned       DATA_W = 32,
  parameter logic [DATA_W-1:0] TAPS   = 32'h80200003,
  parameter logic [DATA_W-1:0] SEED   = 32'h0000102B
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              hex_mode,
  input  logic              seed_load,
  input  logic [DATA_W-1:0] seed,
  output logic              tx,
  output logic              busy,
  output logic              word_done
);

  localparam int unsigned DIV     = CLK_HZ / BAUD;
  localparam int unsigned NIBBLES = DATA_W / 4;
  localparam int unsigned IW      = $clog2(DATA_W + 2);
  localparam int unsigned BW      = $clog2(DATA_W);

  logic [DATA_W-1:0] lfsr, lfsr_next, word, sel_word;
  logic              mode, sel_mode;
  logic [IW-1:0]     char_idx, sel_idx, last_idx, sel_last;
  logic              running, nl_sent, in_frame;
  logic              ready, valid, accept, line_end, cont;
  logic [7:0]        char_byte;
  logic [BW-1:0]     bit_sel, nib_base;

  assign lfsr_next = {lfsr[DATA_W-2:0], ^(lfsr & TAPS)};
  assign last_idx  = mode ? IW'(NIBBLES) : IW'(DATA_W);
  assign line_end  = running && nl_sent && ready;
  assign cont      = line_end && enable;
  assign valid     = running && (!nl_sent || cont);
  assign accept    = valid && ready;
  assign word_done = line_end;
  assign busy      = in_frame;

  // On the final newline stop cycle the next line's first character is offered
  // from the advanced LFSR and live hex_mode, giving seamless back-to-back lines.
  always_comb begin
    sel_word  = line_end ? lfsr_next : word;
    sel_mode  = line_end ? hex_mode : mode;
    sel_idx   = line_end ? '0 : char_idx;
    sel_last  = sel_mode ? IW'(NIBBLES) : IW'(DATA_W);
    bit_sel   = BW'(DATA_W - 1 - int'(sel_idx));
    nib_base  = BW'(4 * (NIBBLES - 1 - int'(sel_idx)));
    if (sel_idx == sel_last)
      char_byte = ASCII_NL;
    else if (sel_mode)
      char_byte = nib_to_ascii(sel_word[nib_base +: 4]);
    else
      char_byte = ASCII_0 + {7'b0, sel_word[bit_sel]};
  end

  // LFSR, word/mode latch and character sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= SEED;
      word     <= '0;
      mode     <= 1'b0;
      char_idx <= '0;
      running  <= 1'b0;
      nl_sent  <= 1'b0;
    end else if (!running) begin
      if (seed_load) begin
        lfsr <= (seed == '0) ? DATA_W'(1) : seed;
      end else if (enable) begin
        running  <= 1'b1;
        word     <= lfsr;
        mode     <= hex_mode;
        char_idx <= '0;
        nl_sent  <= 1'b0;
      end
    end else if (line_end) begin
      lfsr    <= lfsr_next;
      nl_sent <= 1'b0;
      if (enable) begin
        word     <= lfsr_next;
        mode     <= hex_mode;
        char_idx <= IW'(1);
      end else begin
        running  <= 1'b0;
        char_idx <= '0;
      end
    end else if (accept) begin
      if (char_idx == last_idx)
        nl_sent <= 1'b1;
      else
        char_idx <= char_idx + 1'b1;
    end
  end

  // Busy tracks the serialiser being inside a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      in_frame <= 1'b0;
    else if (accept)
      in_frame <= 1'b1;
    else if (ready)
      in_frame <= 1'b0;
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .data (char_byte),
    .valid(valid),
    .ready(ready),
    .tx   (tx)
  );

endmodule
